// File: rtl/adc_pkg.sv
// Shared definitions for the SPI ADC conversion stream: word field layout and averager state type.
// Latency: none (package).
// Backpressure: none (package).
package adc_pkg;

    localparam int SAMPLE_WIDTH = 24;
    localparam int CM_WIDTH     = 8;
    localparam int SAMPLE_MSB   = 31;
    localparam int SAMPLE_LSB   = 8;
    localparam int CM_MSB       = 7;
    localparam int WORD_WIDTH   = SAMPLE_MSB + 1;

    // Conversion word as produced by the SPI ADC front end: [31:8] sample, [7:0] common-mode byte.
    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] sample;
        logic [CM_WIDTH-1:0]     cm;
    } conv_word_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } avg_state_t;

    // Averaging exponent limited to what the accumulator can hold.
    function automatic logic [3:0] clamp_k(input logic [3:0] k, input int max_k);
        if (int'(k) > max_k) begin
            return 4'(max_k);
        end
        return k;
    endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Block accumulator: sums 2^k signed samples, latches k at block start, emits rounded/shifted average.
// Latency: combinational result/block_done on the final handshake of a block.
// Backpressure: none; sample_vld is an already-qualified handshake strobe.
// Ports: aclk/aresetn, enable (low flushes the partial block), log2_avg, sample_vld, sample,
//        block_done (strobe on final sample), result (24-bit average, valid with block_done).
// Build option: ADC_AVG_ROUND_EN adds 2^(k-1) before the shift (round half up); otherwise floor.
module adc_avg_accum
    import adc_pkg::*;
#(
    parameter int MAX_LOG2_AVG = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enable,
    input  logic [3:0]              log2_avg,
    input  logic                    sample_vld,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    block_done,
    output logic [SAMPLE_WIDTH-1:0] result
);

    localparam int AW = SAMPLE_WIDTH + MAX_LOG2_AVG;
    localparam int CW = MAX_LOG2_AVG + 1;

    avg_state_t             state_q, state_d;
    logic                   flush;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   rnd_add;
    logic signed [AW-1:0]   acc_rnd;
    logic signed [AW-1:0]   acc_shift;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          last_idx;
    logic [3:0]             k_q;
    logic [3:0]             k_eff;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode tracking; flush holds the accumulator empty whenever streaming is disabled,
    // including the cycle enable falls so the partial block is dropped at once.
    always_comb begin
        state_d = state_q;
        flush   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACCUM;
                    flush   = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    flush = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // The first sample of a block uses the live exponent; later ones use the latched copy.
        k_eff    = (cnt_q == '0) ? clamp_k(log2_avg, MAX_LOG2_AVG) : k_q;
        last_idx = (CW'(1) << k_eff) - CW'(1);
        block_done = sample_vld && (cnt_q == last_idx);
        acc_sum  = acc_q + AW'($signed(sample));
`ifdef ADC_AVG_ROUND_EN
        rnd_add  = (k_eff == 4'd0) ? '0 : $signed(AW'(1) << (k_eff - 4'd1));
`else
        rnd_add  = '0;
`endif
        acc_rnd   = acc_sum + rnd_add;
        acc_shift = acc_rnd >>> k_eff;
        result    = acc_shift[SAMPLE_WIDTH-1:0];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else if (flush) begin
            acc_q <= '0;
            cnt_q <= '0;
            k_q   <= '0;
        end else if (sample_vld) begin
            if (cnt_q == '0) begin
                k_q <= k_eff;
            end
            if (block_done) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/axis_adc_averager.sv
// AXI-Stream ADC block averager: one averaged word per 2^k samples, tlast every PACKET_LEN words.
// Latency: m_axis_tvalid rises the cycle after a block's final input handshake.
// Backpressure: single output register, no skid; input stalls only while it is full and m_axis_tready=0.
// Ports: aclk/aresetn, enable, log2_avg, s_axis_* (conversion words in), m_axis_* (averaged words out).
// Build option: ADC_AVG_ROUND_EN selects round-half-up averaging instead of floor.
module axis_adc_averager
    import adc_pkg::*;
#(
    parameter int MAX_LOG2_AVG = 8,
    parameter int PACKET_LEN   = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic [3:0]  log2_avg,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready
);

    localparam int PW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

    conv_word_t              in_word;
    logic                    s_hs;
    logic                    block_done;
    logic [SAMPLE_WIDTH-1:0] result;
    logic [PW-1:0]           pkt_q;
    logic                    pkt_last;

    assign in_word       = s_axis_tdata;
    assign s_axis_tready = aresetn & enable & (~m_axis_tvalid | m_axis_tready);
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign pkt_last      = (pkt_q == PW'(PACKET_LEN - 1));

    adc_avg_accum #(
        .MAX_LOG2_AVG (MAX_LOG2_AVG)
    ) u_accum (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (enable),
        .log2_avg   (log2_avg),
        .sample_vld (s_hs),
        .sample     (in_word.sample),
        .block_done (block_done),
        .result     (result)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            pkt_q         <= '0;
        end else begin
            if (block_done) begin
                m_axis_tdata  <= {result, in_word.cm};
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= pkt_last;
                pkt_q         <= pkt_last ? '0 : pkt_q + PW'(1);
            end else begin
                if (m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                end
                // A pending word keeps its tlast; only the count restarts.
                if (!enable) begin
                    pkt_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_adc_averager.sv
module tb_axis_adc_averager;

    localparam int PL = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [3:0]  log2_avg;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    int          blk_q[$];
    int          blk_k = 0;
    int          pkt   = 0;
    logic        exp_vld  = 1'b0;
    logic        exp_last = 1'b0;
    logic [31:0] exp_dat  = '0;
    logic        exp_rdy;

    // Words the DUT actually delivered, with the cycle they were taken
    logic [32:0] got[$];
    int          got_cyc[$];

    always #5 aclk = ~aclk;

    axis_adc_averager #(
        .MAX_LOG2_AVG (8),
        .PACKET_LEN   (PL)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .log2_avg      (log2_avg),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Block average from the arithmetic definition: floor(sum / N), or floor((sum + N/2) / N).
    function automatic int block_avg(input int k);
        longint sum = 0;
        longint n   = longint'(1) << k;
        longint q;
        foreach (blk_q[i]) sum += blk_q[i];
`ifdef ADC_AVG_ROUND_EN
        sum += n / 2;
`endif
        q = sum / n;
        if ((sum % n != 0) && (sum < 0)) q -= 1;
        return int'(q);
    endfunction

    // Compare DUT against the model, then advance the model using the inputs that
    // the DUT will see at the next rising edge.
    always @(negedge aclk) begin
        int          smp;
        int          res;
        logic [31:0] r32;
        logic        new_out;
        cyc++;
        if (!aresetn) begin
            blk_q.delete();
            pkt      = 0;
            exp_vld  = 1'b0;
            exp_last = 1'b0;
            exp_dat  = '0;
            chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
            chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
        end
        chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_vld));
        if (exp_vld) begin
            chk("m_tdata", 64'(m_axis_tdata), 64'(exp_dat));
            chk("m_tlast", 64'(m_axis_tlast), 64'(exp_last));
        end
        exp_rdy = aresetn && enable && (!exp_vld || m_axis_tready);
        chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            got.push_back({m_axis_tlast, m_axis_tdata});
            got_cyc.push_back(cyc);
        end
        if (aresetn) begin
            new_out = 1'b0;
            if (!enable) begin
                blk_q.delete();
                pkt = 0;
            end
            if (s_axis_tvalid && exp_rdy) begin
                if (blk_q.size() == 0) blk_k = (log2_avg > 4'd8) ? 8 : int'(log2_avg);
                smp = int'($signed(s_axis_tdata[31:8]));
                blk_q.push_back(smp);
                if (blk_q.size() == (1 << blk_k)) begin
                    res = block_avg(blk_k);
                    r32 = 32'(res);
                    exp_dat = {r32[23:0], s_axis_tdata[7:0]};
                    new_out = 1'b1;
                    blk_q.delete();
                end
            end
            if (new_out) begin
                exp_vld  = 1'b1;
                exp_last = (pkt == PL - 1);
                pkt      = (pkt + 1) % PL;
            end else if (m_axis_tready) begin
                exp_vld = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic send(input int smp, input logic [7:0] cm);
        int n = 0;
        s_axis_tdata  = {smp[23:0], cm};
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_axis_tready) break;
            n++;
            if (n > 300) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        @(posedge aclk);
        #2;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic restart_pkt();
        m_axis_tready = 1'b1;
        step();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        got.delete();
        got_cyc.delete();
    endtask

    task automatic chk_word(input string name, input int idx, input logic last, input int smp,
                            input logic [7:0] cm);
        logic [32:0] w;
        w = {last, smp[23:0], cm};
        chk(name, 64'(got[idx]), 64'(w));
    endtask

    initial begin
        int e0;
        int e1;
        aresetn       = 1'b0;
        enable        = 1'b1;
        log2_avg      = 4'd0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("rst_s_tready_low", 64'(s_axis_tready), 64'(0));
        chk("rst_m_tvalid_low", 64'(m_axis_tvalid), 64'(0));
        step();
        aresetn = 1'b1;
        step();

        // k=2 truncation / rounding, positive and negative blocks
        restart_pkt();
        log2_avg = 4'd2;
        for (int i = 1; i <= 4; i++) send(i, 8'h5A);
        for (int i = 1; i <= 4; i++) send(-i, 8'h5A);
        repeat (3) step();
`ifdef ADC_AVG_ROUND_EN
        e0 = 3;  e1 = -2;
`else
        e0 = 2;  e1 = -3;
`endif
        chk("k2_count", 64'(got.size()), 64'(2));
        chk_word("k2_word0", 0, 1'b0, e0, 8'h5A);
        chk_word("k2_word1", 1, 1'b0, e1, 8'h5A);

        // k=0 pass-through at full rate, tlast on words 4 and 8
        restart_pkt();
        log2_avg = 4'd0;
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 32'h7FFFFF : 32'h800000, 8'(i));
        repeat (3) step();
        chk("k0_count", 64'(got.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk_word("k0_word", i, (i == 3 || i == 7), (i % 2 == 0) ? 32'h7FFFFF : 32'h800000, 8'(i));
            if (i > 0) chk("k0_spacing", 64'(got_cyc[i] - got_cyc[i-1]), 64'(1));
        end

        // k=3 with output stalled: input blocks, then resumes without loss or duplication
        restart_pkt();
        log2_avg      = 4'd3;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(10, 8'h01);
        fork
            send(20, 8'h02);
            begin
                repeat (3) @(negedge aclk);
                chk("stall_s_tready", 64'(s_axis_tready), 64'(0));
                chk("stall_m_tvalid", 64'(m_axis_tvalid), 64'(1));
                chk("stall_none_taken", 64'(got.size()), 64'(0));
                @(posedge aclk);
                #2;
                m_axis_tready = 1'b1;
            end
        join
        for (int i = 0; i < 7; i++) send(20, 8'h02);
        repeat (3) step();
        chk("stall_count", 64'(got.size()), 64'(2));
        chk_word("stall_word0", 0, 1'b0, 10, 8'h01);
        chk_word("stall_word1", 1, 1'b0, 20, 8'h02);

        // log2_avg change mid-block takes effect at the next block
        restart_pkt();
        log2_avg = 4'd1;
        send(4, 8'h03);
        log2_avg = 4'd3;
        send(6, 8'h03);
        for (int i = 1; i <= 8; i++) send(i, 8'h04);
        repeat (3) step();
`ifdef ADC_AVG_ROUND_EN
        e1 = 5;
`else
        e1 = 4;
`endif
        chk("kchg_count", 64'(got.size()), 64'(2));
        chk_word("kchg_word0", 0, 1'b0, 5, 8'h03);
        chk_word("kchg_word1", 1, 1'b0, e1, 8'h04);

        // enable drop discards the partial block and restarts the packet count
        restart_pkt();
        log2_avg = 4'd0;
        send(100, 8'h09);
        send(101, 8'h09);
        log2_avg = 4'd3;
        for (int i = 0; i < 5; i++) send(50, 8'h09);
        enable = 1'b0;
        repeat (4) step();
        chk("dis_no_output", 64'(got.size()), 64'(2));
        enable   = 1'b1;
        log2_avg = 4'd0;
        got.delete();
        got_cyc.delete();
        for (int i = 0; i < PL; i++) send(200 + i, 8'h09);
        repeat (3) step();
        chk("dis_count", 64'(got.size()), 64'(PL));
        for (int i = 0; i < PL; i++) chk("dis_tlast", 64'(got[i][32]), 64'(i == PL - 1));

        // reset with a held output word, then reset mid-block
        restart_pkt();
        m_axis_tready = 1'b0;
        log2_avg      = 4'd2;
        for (int i = 0; i < 4; i++) send(-7, 8'h01);
        step();
        chk("rst_pre_valid", 64'(m_axis_tvalid), 64'(1));
        aresetn = 1'b0;
        @(negedge aclk);
        chk("rst_mid_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_mid_tdata", 64'(m_axis_tdata), 64'(0));
        step();
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        step();
        step();
        chk("rst_no_survivor", 64'(got.size()), 64'(0));
        log2_avg = 4'd3;
        for (int i = 0; i < 3; i++) send(1000, 8'h01);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        for (int i = 0; i < 8; i++) send(7, 8'h06);
        repeat (3) step();
        chk("rst_fresh_count", 64'(got.size()), 64'(1));
        chk_word("rst_fresh_word", 0, 1'b0, 7, 8'h06);

        // exponent above MAX_LOG2_AVG is clamped to 8 (256-sample block)
        restart_pkt();
        log2_avg = 4'd15;
        for (int i = 0; i < 256; i++) send(-5, 8'h03);
        repeat (3) step();
        chk("clamp_count", 64'(got.size()), 64'(1));
        chk_word("clamp_word", 0, 1'b0, -5, 8'h03);

        // randomized traffic against the model
        restart_pkt();
        for (int c = 0; c < 4000; c++) begin
            step();
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = $urandom;
            m_axis_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0)
                log2_avg = ($urandom_range(0, 9) == 0) ? 4'd9 : 4'($urandom_range(0, 4));
            enable = ($urandom_range(0, 250) != 0);
        end
        step();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
